// File: rtl/register_file_onehot.sv
// NUM_REGS x DATA_WIDTH register file driven by a one-hot select word, with R0 base-address gating.
// Optional select-word checking is enabled by defining REGFILE_ONEHOT_CHECK_EN.
module register_file_onehot #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NUM_REGS-1:0]   regSelect,
  input  logic                  Rin,
  input  logic                  Rout,
  input  logic                  BAout,
  input  logic [DATA_WIDTH-1:0] busIn,
  output logic [DATA_WIDTH-1:0] busOut,
  output logic                  busOutValid,
  output logic                  selErr
);

  typedef enum logic [1:0] {HOLD, LOAD, ZERO} entry_op_e;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  entry_op_e             op   [NUM_REGS];
  logic                  rd_strobe;
  logic                  sel_bad;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;

  assign rd_strobe = Rout | BAout;

`ifdef REGFILE_ONEHOT_CHECK_EN
  assign sel_bad = (Rin | Rout | BAout) && ($countones(regSelect) != 1);
`else
  assign sel_bad = 1'b0;
`endif

  assign wr_en = Rin & ~sel_bad;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      op[i] = HOLD;
      if (clear)
        op[i] = ZERO;
      else if (wr_en && regSelect[i])
        op[i] = LOAD;
    end
  end

  // OR of all selected entries; R0 is masked while BAout is active
  always_comb begin
    rd_data = '0;
    if (!sel_bad) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (regSelect[i] && !(BAout && i == 0))
          rd_data = rd_data | regs[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      case (op[i])
        ZERO:    regs[i] <= '0;
        LOAD:    regs[i] <= busIn;
        default: regs[i] <= regs[i];
      endcase
    end
  end

  // Read samples pre-write contents, so read-during-write returns the old value
  always_ff @(posedge clock) begin
    if (clear) begin
      busOut      <= '0;
      busOutValid <= 1'b0;
      selErr      <= 1'b0;
    end else begin
      busOutValid <= rd_strobe;
      selErr      <= sel_bad;
      if (rd_strobe)
        busOut <= rd_data;
    end
  end

endmodule
